// File: rtl/soc_mem2ahb4.sv
// Single-transfer bridge from a simple req/ack memory port to an AHB4 master.
// All outputs come from flops; one transfer in flight, no address pipelining.
//
// state | meaning
// IDLE  | waiting for a request, ack pulse cycle lives here
// ADDR  | NONSEQ address phase on the bus, held until hready
// DATA  | data phase, waiting for hready to complete
// ERR   | illegal byte-enable, one quiet cycle before error ack
module soc_mem2ahb4 #(
   parameter int PLEN = 32,
   parameter int XLEN = 32,
   localparam int SW  = XLEN/8
) (
   input  logic            ahb4_clk_i,
   input  logic            ahb4_rst_i,
   input  logic            mem_req_i,
   input  logic            mem_we_i,
   input  logic [PLEN-1:0] mem_addr_i,
   input  logic [XLEN-1:0] mem_wdata_i,
   input  logic [SW-1:0]   mem_be_i,
   output logic            mem_ack_o,
   output logic            mem_err_o,
   output logic [XLEN-1:0] mem_rdata_o,
   output logic            ahb4_hsel_o,
   output logic [PLEN-1:0] ahb4_haddr_o,
   output logic [XLEN-1:0] ahb4_hwdata_o,
   output logic            ahb4_hwrite_o,
   output logic [2:0]      ahb4_hsize_o,
   output logic [2:0]      ahb4_hburst_o,
   output logic [3:0]      ahb4_hprot_o,
   output logic [1:0]      ahb4_htrans_o,
   output logic            ahb4_hmastlock_o,
   input  logic [XLEN-1:0] ahb4_hrdata_i,
   input  logic            ahb4_hready_i,
   input  logic            ahb4_hresp_i
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_ERR
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_t            state_q, state_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              hsel_q, hsel_d;
   logic [PLEN-1:0]   haddr_q, haddr_d;
   logic [XLEN-1:0]   hwdata_q, hwdata_d;
   logic              hwrite_q, hwrite_d;
   logic [2:0]        hsize_q, hsize_d;
   logic [1:0]        htrans_q, htrans_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;

   logic              be_legal;
   logic [1:0]        be_lsb;
   logic [2:0]        be_size;

   // Address low bits come from the byte enables, not from the request address.
   logic              unused_addr_lsb;
   assign unused_addr_lsb = ^mem_addr_i[1:0];

   always_comb begin
      be_legal = 1'b1;
      be_lsb   = 2'b00;
      be_size  = 3'b010;
      case (mem_be_i)
         4'b1111: begin be_size = 3'b010; be_lsb = 2'b00; end
         4'b0011: begin be_size = 3'b001; be_lsb = 2'b00; end
         4'b1100: begin be_size = 3'b001; be_lsb = 2'b10; end
         4'b0001: begin be_size = 3'b000; be_lsb = 2'b00; end
         4'b0010: begin be_size = 3'b000; be_lsb = 2'b01; end
         4'b0100: begin be_size = 3'b000; be_lsb = 2'b10; end
         4'b1000: begin be_size = 3'b000; be_lsb = 2'b11; end
         default: be_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      hsel_d   = hsel_q;
      haddr_d  = haddr_q;
      hwdata_d = hwdata_q;
      hwrite_d = hwrite_q;
      hsize_d  = hsize_q;
      htrans_d = htrans_q;
      wdata_d  = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_req_i && !ack_q) begin
               wdata_d = mem_wdata_i;
               if (be_legal) begin
                  haddr_d  = {mem_addr_i[PLEN-1:2], be_lsb};
                  hwrite_d = mem_we_i;
                  hsize_d  = be_size;
                  hsel_d   = 1'b1;
                  htrans_d = HTRANS_NONSEQ;
                  state_d  = ST_ADDR;
               end else begin
                  state_d  = ST_ERR;
               end
            end
         end
         ST_ADDR: begin
            if (ahb4_hready_i) begin
               hsel_d   = 1'b0;
               htrans_d = HTRANS_IDLE;
               hwdata_d = wdata_q;
               state_d  = ST_DATA;
            end
         end
         ST_DATA: begin
            // hresp alone is the first ERROR cycle; only the hready edge matters
            if (ahb4_hready_i) begin
               ack_d = 1'b1;
               err_d = ahb4_hresp_i;
               if (!hwrite_q && !ahb4_hresp_i) begin
                  rdata_d = ahb4_hrdata_i;
               end
               state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ahb4_clk_i) begin
      if (!ahb4_rst_i) begin
         state_q  <= ST_IDLE;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         hsel_q   <= 1'b0;
         haddr_q  <= '0;
         hwdata_q <= '0;
         hwrite_q <= 1'b0;
         hsize_q  <= 3'b000;
         htrans_q <= HTRANS_IDLE;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         hsel_q   <= hsel_d;
         haddr_q  <= haddr_d;
         hwdata_q <= hwdata_d;
         hwrite_q <= hwrite_d;
         hsize_q  <= hsize_d;
         htrans_q <= htrans_d;
         wdata_q  <= wdata_d;
      end
   end

   assign mem_ack_o        = ack_q;
   assign mem_err_o        = err_q;
   assign mem_rdata_o      = rdata_q;
   assign ahb4_hsel_o      = hsel_q;
   assign ahb4_haddr_o     = haddr_q;
   assign ahb4_hwdata_o    = hwdata_q;
   assign ahb4_hwrite_o    = hwrite_q;
   assign ahb4_hsize_o     = hsize_q;
   assign ahb4_htrans_o    = htrans_q;
   assign ahb4_hburst_o    = 3'b000;
   assign ahb4_hprot_o     = 4'b0011;
   assign ahb4_hmastlock_o = 1'b0;

endmodule
